// File: rtl/bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
//
// Multi-digit synchronous BCD counter. It accumulates the enable/carry stream
// of an upstream counter stage as a decimal count. Instances chain through
// eu -> ei, and a sticky overflow flag records every wrap-around.
//
// Parameters:
//   DIGITS  number of BCD digits (1..8); the count is 4*DIGITS bits wide
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous active-high reset (q=0, ov=0)
//   ei      in   count enable (upstream carry)
//   load    in   synchronous parallel load of din (nibbles > 9 load as 0)
//   din     in   load value, digit 0 in bits [3:0]
//   clr_ov  in   clears the sticky overflow flag (a wrap on the same edge wins)
//   dir     in   0 = up, 1 = down (present only with BCD_COUNTER_DOWN_EN)
//   q       out  current BCD count, digit 0 least significant
//   eu      out  combinational carry: ei & every digit at its terminal value
//   ov      out  sticky overflow flag
//
// Build option:
//   BCD_COUNTER_DOWN_EN  adds the dir port and down counting
// Edge priority: reset, then load, then ei.
// ---------------------------------------------------------------------------
module bcd_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ei,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  clr_ov,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic                  dir,
`endif
  output logic [4*DIGITS-1:0]   q,
  output logic                  eu,
  output logic                  ov
);

  logic [DIGITS-1:0][3:0] digits_q, digits_d;
  logic                   ov_q, ov_d;

  // Counting direction; tied to up when the down option is not built.
  logic                   down;
`ifdef BCD_COUNTER_DOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  // Value at which a digit rolls over and passes the carry/borrow on.
  logic [3:0] terminal;
  assign terminal = down ? 4'd0 : 4'd9;

  // en[k]: digit k steps this edge. en[k+1] requires digit k to be at its
  // terminal value, so en[DIGITS] is exactly the ripple carry out.
  logic [DIGITS:0] en;

  always_comb begin
    en    = '0;
    en[0] = ei;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      en[k+1] = en[k] & (digits_q[k] == terminal);
    end
  end

  assign eu = en[DIGITS];

  always_comb begin
    digits_d = digits_q;
    ov_d     = ov_q & ~clr_ov;
    if (load) begin
      // Out-of-range nibbles are forced to 0 so no illegal code is reachable.
      for (int unsigned k = 0; k < DIGITS; k++) begin
        digits_d[k] = (din[4*k +: 4] > 4'd9) ? 4'd0 : din[4*k +: 4];
      end
    end else if (ei) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        if (en[k]) begin
          if (down) begin
            digits_d[k] = (digits_q[k] == 4'd0) ? 4'd9 : digits_q[k] - 4'd1;
          end else begin
            digits_d[k] = (digits_q[k] == 4'd9) ? 4'd0 : digits_q[k] + 4'd1;
          end
        end
      end
      // A full-width wrap sets the flag even if clr_ov is asserted.
      if (en[DIGITS]) begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      digits_q <= '0;
      ov_q     <= 1'b0;
    end else begin
      digits_q <= digits_d;
      ov_q     <= ov_d;
    end
  end

  assign q  = digits_q;
  assign ov = ov_q;

endmodule

// File: tb/tb_bcd_counter.sv
module tb_bcd_counter;

  localparam int unsigned DIGITS = 4;
  localparam int          MAXV   = 9999;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, ei_drv, load, clr_ov, dir_drv;
  logic [15:0] din;
  logic [15:0] q;
  logic        eu, ov;

  // Upstream base-2 stage model: one toggle bit, carry = its ei & bit.
  logic        chain_mode, up_ei, tog;
  logic        ei;
  assign ei = chain_mode ? (up_ei & tog) : ei_drv;

  always @(posedge clock) begin
    if (reset)      tog <= 1'b0;
    else if (up_ei) tog <= ~tog;
  end

  bcd_counter #(.DIGITS(DIGITS)) dut (
    .clock  (clock),
    .reset  (reset),
    .ei     (ei),
    .load   (load),
    .din    (din),
    .clr_ov (clr_ov),
`ifdef BCD_COUNTER_DOWN_EN
    .dir    (dir_drv),
`endif
    .q      (q),
    .eu     (eu),
    .ov     (ov)
  );

  typedef struct {
    logic [15:0] q;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   m_val  = 0;
  logic m_ov   = 1'b0;
  logic exp_eu;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_din(input logic [15:0] d);
    int v;
    int w;
    int n;
    v = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      n = int'(d[4*i +: 4]);
      if (n > 9) n = 0;
      v = v + n * w;
      w = w * 10;
    end
    return v;
  endfunction

  // Drive one cycle's inputs at the falling edge, predict eu for this cycle
  // and push the state expected after the next rising edge.
  task automatic drive(input logic r, input logic l, input logic e,
                       input logic c, input logic d, input logic [15:0] dv);
    exp_t x;
    @(negedge clock);
    reset = r; load = l; ei_drv = e; clr_ov = c; dir_drv = d; din = dv;
    exp_eu = e && (d ? (m_val == 0) : (m_val == MAXV));
    if (r) begin
      m_val = 0;
      m_ov  = 1'b0;
    end else if (l) begin
      m_val = from_din(dv);
      if (c) m_ov = 1'b0;
    end else begin
      if (c) m_ov = 1'b0;
      if (e) begin
        if (!d) begin
          if (m_val == MAXV) begin m_val = 0; m_ov = 1'b1; end
          else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin m_val = MAXV; m_ov = 1'b1; end
          else m_val = m_val - 1;
        end
      end
    end
    x.q  = to_bcd(m_val);
    x.ov = m_ov;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 27; i++) begin
      if (i < 2) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      else       drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      #1;
      checks++;
      if (eu !== exp_eu) begin
        errors++; $display("FAIL reset_eu cyc=%0d got=%b exp=%b", i, eu, exp_eu);
      end
      tick();
      x = sb.pop_front();
      checks++;
      if (q !== x.q || ov !== x.ov) begin
        errors++; $display("FAIL reset_count cyc=%0d got q=%h ov=%b exp q=%h ov=%b", i, q, ov, x.q, x.ov);
      end
    end
    checks++;
    if (q !== 16'h0025) begin
      errors++; $display("FAIL reset_final got=%h exp=0025", q);
    end
  endtask

  task automatic test_decade();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0099);
      else        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      #1;
      checks++;
      if (eu !== 1'b0) begin
        errors++; $display("FAIL decade_eu cyc=%0d got=%b exp=0", i, eu);
      end
      tick();
      x = sb.pop_front();
      checks++;
      if (q !== x.q || ov !== x.ov) begin
        errors++; $display("FAIL decade cyc=%0d got q=%h ov=%b exp q=%h ov=%b", i, q, ov, x.q, x.ov);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    x = sb.pop_front();
    checks++;
    if (q !== 16'h0100 || q !== x.q) begin
      errors++; $display("FAIL decade_final got=%h exp=0100", q);
    end
  endtask

  task automatic test_wrap();
    exp_t x;
    logic want_eu [0:2] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h9998);
      else        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      #1;
      checks++;
      if (eu !== exp_eu || eu !== want_eu[i]) begin
        errors++; $display("FAIL wrap_eu cyc=%0d got=%b exp=%b", i, eu, want_eu[i]);
      end
      tick();
      x = sb.pop_front();
      checks++;
      if (q !== x.q || ov !== x.ov) begin
        errors++; $display("FAIL wrap cyc=%0d got q=%h ov=%b exp q=%h ov=%b", i, q, ov, x.q, x.ov);
      end
    end
    checks++;
    if (q !== 16'h0000 || ov !== 1'b1) begin
      errors++; $display("FAIL wrap_final got q=%h ov=%b exp q=0000 ov=1", q, ov);
    end
    // ov holds through idle cycles, then clears on clr_ov.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, (i == 3), 1'b0, 16'h0000);
      tick();
      x = sb.pop_front();
      checks++;
      if (ov !== x.ov || q !== x.q) begin
        errors++; $display("FAIL sticky_ov cyc=%0d got ov=%b q=%h exp ov=%b q=%h", i, ov, q, x.ov, x.q);
      end
    end
    checks++;
    if (ov !== 1'b0) begin
      errors++; $display("FAIL clr_ov got=%b exp=0", ov);
    end
  endtask

  task automatic test_priority();
    exp_t x;
    logic [15:0] want [0:3] = '{16'h1207, 16'h0000, 16'h9999, 16'h0000};
    logic        wov  [0:3] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h12A7);
        1: drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h5555);
        2: drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h9999);
        default: drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      endcase
      #1;
      checks++;
      if (eu !== exp_eu) begin
        errors++; $display("FAIL prio_eu cyc=%0d got=%b exp=%b", i, eu, exp_eu);
      end
      tick();
      x = sb.pop_front();
      checks++;
      if (q !== x.q || ov !== x.ov || q !== want[i] || ov !== wov[i]) begin
        errors++; $display("FAIL prio cyc=%0d got q=%h ov=%b exp q=%h ov=%b", i, q, ov, want[i], wov[i]);
      end
    end
  endtask

  task automatic test_chain();
    exp_t x;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    x = sb.pop_front();
    checks++;
    if (q !== x.q || ov !== x.ov) begin
      errors++; $display("FAIL chain_reset got q=%h ov=%b exp q=%h ov=%b", q, ov, x.q, x.ov);
    end
    @(negedge clock);
    reset = 1'b0; chain_mode = 1'b1; up_ei = 1'b1;
    repeat (20) @(posedge clock);
    @(negedge clock);
    up_ei = 1'b0;
    #1;
    checks++;
    if (!(q == 16'h0009 || q == 16'h0010 || q == 16'h0011) || ov !== 1'b0) begin
      errors++; $display("FAIL chain got q=%h ov=%b exp q=0010 (+/-1) ov=0", q, ov);
    end
    chain_mode = 1'b0;
    m_val = 0;
    for (int i = 0; i < 4; i++) m_val = m_val * 10 + int'(q[4*(3-i) +: 4]);
  endtask

`ifdef BCD_COUNTER_DOWN_EN
  task automatic test_down();
    exp_t x;
    logic [15:0] want [0:2] = '{16'h0001, 16'h0000, 16'h9999};
    logic        weu  [0:2] = '{1'b0, 1'b0, 1'b1};
    logic        wov  [0:2] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001);
      else        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
      #1;
      checks++;
      if (eu !== exp_eu || eu !== weu[i]) begin
        errors++; $display("FAIL down_eu cyc=%0d got=%b exp=%b", i, eu, weu[i]);
      end
      tick();
      x = sb.pop_front();
      checks++;
      if (q !== x.q || ov !== x.ov || q !== want[i] || ov !== wov[i]) begin
        errors++; $display("FAIL down cyc=%0d got q=%h ov=%b exp q=%h ov=%b", i, q, ov, want[i], wov[i]);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; load = 1'b0; ei_drv = 1'b0; clr_ov = 1'b0; dir_drv = 1'b0;
    din = '0; chain_mode = 1'b0; up_ei = 1'b0;
    test_reset();
    test_decade();
    test_wrap();
    test_priority();
    test_chain();
`ifdef BCD_COUNTER_DOWN_EN
    test_down();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
